// File: rtl/cfg_bus_arbiter.sv
// Round-robin arbiter sharing one Config-style slave bus among NUM_REQ requesters.
// Optional requester lock (atomic sequences) is compiled in with `define CFG_ARB_LOCK_EN.
module cfg_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
`ifdef CFG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            lock,
`endif
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic                          bus_r_en,
  output logic                          bus_w_en,
  output logic [DATA_WIDTH-1:0]         bus_write_data,
  input  logic [DATA_WIDTH-1:0]         bus_read_data,
  output logic [1:0]                    state_dbg
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [PW-1:0] ptr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                state, state_d;
  ptr_t                  last, last_d;
  logic                  op_q, op_d;
  logic [NUM_REQ-1:0]    grant_d, done_d, eligible;
  logic [DATA_WIDTH-1:0] rdata_d, wd_d;
  logic                  r_en_d, w_en_d;
  logic                  found;
  ptr_t                  winner;
`ifdef CFG_ARB_LOCK_EN
  logic                  lock_active, lock_d;
`endif

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Winner search: first eligible index after the last owner, wrapping.
  always_comb begin
    int   idx;
    ptr_t cand;
    eligible = req & ~done;
`ifdef CFG_ARB_LOCK_EN
    if (lock_active) eligible = req;
`endif
    found  = 1'b0;
    winner = last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last) + k) % NUM_REQ;
      cand = ptr_t'(idx);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`ifdef CFG_ARB_LOCK_EN
    // A locked owner keeps the bus while it still requests; pointer stays put.
    if (lock_active && req[last]) begin
      found  = 1'b1;
      winner = last;
    end
`endif
  end

  always_comb begin
    state_d = state;
    last_d  = last;
    op_d    = op_q;
    grant_d = grant;
    done_d  = '0;
    rdata_d = rdata;
    wd_d    = bus_write_data;
    r_en_d  = 1'b0;
    w_en_d  = 1'b0;
`ifdef CFG_ARB_LOCK_EN
    lock_d  = lock_active;
`endif
    case (state)
      IDLE: begin
        grant_d = '0;
        if (found) begin
          grant_d[winner] = 1'b1;
          last_d  = winner;
          op_d    = op[winner];
          wd_d    = wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
          r_en_d  = ~op[winner];
          w_en_d  = op[winner];
          state_d = ISSUE;
`ifdef CFG_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end
      end
      ISSUE: begin
        if (!op_q) begin
          grant_d = '0;
          done_d  = grant;
          state_d = IDLE;
`ifdef CFG_ARB_LOCK_EN
          lock_d  = lock[last];
`endif
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // Slave read data was refreshed by the fetch strobe of the ISSUE cycle.
        rdata_d = bus_read_data;
        grant_d = '0;
        done_d  = grant;
        state_d = IDLE;
`ifdef CFG_ARB_LOCK_EN
        lock_d  = lock[last];
`endif
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      last           <= ptr_t'(NUM_REQ-1);
      op_q           <= 1'b0;
      grant          <= '0;
      done           <= '0;
      rdata          <= '0;
      bus_r_en       <= 1'b0;
      bus_w_en       <= 1'b0;
      bus_write_data <= '0;
`ifdef CFG_ARB_LOCK_EN
      lock_active    <= 1'b0;
`endif
    end else begin
      state          <= state_d;
      last           <= last_d;
      op_q           <= op_d;
      grant          <= grant_d;
      done           <= done_d;
      rdata          <= rdata_d;
      bus_r_en       <= r_en_d;
      bus_w_en       <= w_en_d;
      bus_write_data <= wd_d;
`ifdef CFG_ARB_LOCK_EN
      lock_active    <= lock_d;
`endif
    end
  end

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Bench for cfg_bus_arbiter: per-cycle vector table plus directed multi-cycle sequences.
// Builds the lock sequence when CFG_ARB_LOCK_EN is defined.
module tb_cfg_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    op = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    grant, done;
  logic [DW-1:0]   rdata, bus_write_data;
  logic [DW-1:0]   bus_read_data = '0;
  logic            busy, bus_r_en, bus_w_en;
  logic [1:0]      state_dbg;
  logic [DW-1:0]   mem = '0;
`ifdef CFG_ARB_LOCK_EN
  logic [N-1:0]    lock = '0;
`endif

  int tests = 0;
  int failed = 0;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]    req;
    logic [N-1:0]    op;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic            r_en;
    logic            w_en;
    logic [DW-1:0]   bwd;
    logic [DW-1:0]   rdata;
  } vec_t;

  vec_t vecs[15];

  // clock / reset
  always #5 clk = ~clk;

  cfg_bus_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .op(op),
    .wdata(wdata),
`ifdef CFG_ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(grant),
    .done(done),
    .rdata(rdata),
    .busy(busy),
    .bus_r_en(bus_r_en),
    .bus_w_en(bus_w_en),
    .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data),
    .state_dbg(state_dbg)
  );

  // slave: store on r_en, return stored value one cycle after w_en
  always @(posedge clk) begin
    if (bus_r_en) mem <= bus_write_data;
    if (bus_w_en) bus_read_data <= mem;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    op = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({grant, done, busy, bus_r_en, bus_w_en, bus_write_data, rdata});
  endfunction

  function automatic logic [63:0] exp_outs(input vec_t v);
    return 64'({v.grant, v.done, v.busy, v.r_en, v.w_en, v.bwd, v.rdata});
  endfunction

  initial begin
    // row: inputs held across one edge, outputs expected just after that edge
    vecs[0]  = '{4'b0001, 4'b0000, 32'h000000A5, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 8'hA5, 8'h00};
    vecs[1]  = '{4'b0001, 4'b0000, 32'h000000A5, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00};
    vecs[2]  = '{4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00};
    vecs[3]  = '{4'b0100, 4'b0000, 32'h003C0000, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h00};
    vecs[4]  = '{4'b0100, 4'b0000, 32'h003C0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00};
    vecs[5]  = '{4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00};
    vecs[6]  = '{4'b0100, 4'b0100, 32'h00770000, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 8'h77, 8'h00};
    vecs[7]  = '{4'b0100, 4'b0000, 32'h00990000, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h77, 8'h00};
    vecs[8]  = '{4'b0100, 4'b0000, 32'h00990000, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 8'h77, 8'h3C};
    vecs[9]  = '{4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h77, 8'h3C};
    vecs[10] = '{4'b1010, 4'b0000, 32'h5A001100, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 8'h5A, 8'h3C};
    vecs[11] = '{4'b1010, 4'b0000, 32'h5A001100, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h3C};
    vecs[12] = '{4'b0010, 4'b0000, 32'h5A001100, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 8'h11, 8'h3C};
    vecs[13] = '{4'b0010, 4'b0000, 32'h5A001100, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h11, 8'h3C};
    vecs[14] = '{4'b0000, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h11, 8'h3C};

    // reset with requests asserted: everything must come up zero
    rst_n = 1'b0;
    req = 4'b1111;
    op = 4'b1111;
    wdata = 32'hFFFFFFFF;
    tick();
    tick();
    chk("reset_outs", outs(), 64'd0);
    chk("reset_state", 64'(state_dbg), 64'd0);
    req = '0;
    op = '0;
    rst_n = 1'b1;

    // vector table: single store, store+fetch on requester 2, rotation after masking
    for (int i = 0; i < 15; i++) begin
      req = vecs[i].req;
      op = vecs[i].op;
      wdata = vecs[i].wdata;
      tick();
      chk($sformatf("vec%0d", i), outs(), exp_outs(vecs[i]));
    end

    // all four stores held from reset: strict rotation, one done every 2 cycles
    do_reset();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    req = 4'b1111;
    op = 4'b0000;
    wdata = 32'h44332211;
    begin
      logic [N-1:0] prev_g;
      prev_g = '0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (k % 2 == 0) begin
          prev_g = exp_q.pop_front();
          chk($sformatf("rr_grant%0d", k), 64'(grant), 64'(prev_g));
          chk($sformatf("rr_done%0d", k), 64'(done), 64'd0);
          chk($sformatf("rr_ren%0d", k), 64'(bus_r_en), 64'd1);
        end else begin
          chk($sformatf("rr_grant%0d", k), 64'(grant), 64'd0);
          chk($sformatf("rr_done%0d", k), 64'(done), 64'(prev_g));
        end
      end
    end
    req = '0;
    tick();
    tick();

    // reset while a fetch of requester 3 sits in CAPTURE
    do_reset();
    req = 4'b1000;
    op = 4'b1000;
    tick();
    chk("rc_issue_wen", 64'({grant, bus_w_en}), 64'({4'b1000, 1'b1}));
    tick();
    chk("rc_capture", 64'({grant, busy, state_dbg}), 64'({4'b1000, 1'b1, 2'd2}));
    rst_n = 1'b0;
    req = 4'b1010;
    op = 4'b0000;
    wdata = 32'hC3001200;
    tick();
    chk("rc_reset_outs", outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rc_first_grant", 64'({grant, done}), 64'({4'b0010, 4'b0000}));
    tick();
    chk("rc_done1", 64'({grant, done}), 64'({4'b0000, 4'b0010}));
    tick();
    chk("rc_grant3", 64'({grant, bus_write_data}), 64'({4'b1000, 8'hC3}));
    tick();
    chk("rc_done3", 64'({grant, done}), 64'({4'b0000, 4'b1000}));
    req = '0;
    tick();

    // fetch on requester 0, req/op/wdata dropped right after grant
    req = 4'b0001;
    op = 4'b0001;
    wdata = 32'h00000000;
    tick();
    chk("drop_grant", 64'({grant, bus_r_en, bus_w_en}), 64'({4'b0001, 1'b0, 1'b1}));
    req = '0;
    op = '0;
    wdata = 32'hFFFFFFFF;
    tick();
    chk("drop_capture", 64'({grant, busy, bus_r_en, bus_w_en, done}),
        64'({4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000}));
    tick();
    chk("drop_done", 64'({done, rdata, bus_write_data}), 64'({4'b0001, 8'hC3, 8'h00}));
    tick();
    chk("drop_quiet1", 64'({grant, done, busy}), 64'd0);
    tick();
    chk("drop_quiet2", 64'({grant, done, busy}), 64'd0);

`ifdef CFG_ARB_LOCK_EN
    // locked requester 0 keeps the bus until lock drops, then requester 1
    do_reset();
    lock = 4'b0001;
    req = 4'b0011;
    op = 4'b0000;
    wdata = 32'h00000000;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k % 2 == 0) chk($sformatf("lk_grant%0d", k), 64'(grant), 64'(4'b0001));
      else chk($sformatf("lk_done%0d", k), 64'(done), 64'(4'b0001));
    end
    lock = 4'b0000;
    tick();
    chk("lk_done5", 64'(done), 64'(4'b0001));
    tick();
    chk("lk_grant6", 64'(grant), 64'(4'b0010));
    req = '0;
    tick();
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cfg_bus_arbiter.md
Name: cfg_bus_arbiter

Overview:
- Round-robin arbiter that shares one Config-style slave bus among NUM_REQ requesters.
- Slave bus signals: r_en = store write_data into the slave; w_en = slave returns its stored value on read_data one cycle later.
- Each requester posts a store or fetch request. The arbiter serialises them, drives the slave strobes, captures fetch data and returns a per-requester done pulse.
- Sits between requester blocks and a single Slave instance inside the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, bus data width.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  NUM_REQ  per-requester request; held until its done.
- op  input  NUM_REQ  per-requester op: 0 = store (r_en), 1 = fetch (w_en); sampled with req.
- wdata  input  NUM_REQ*DATA_WIDTH  store data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- grant  output  NUM_REQ  one-hot, registered; owner of the current transaction.
- done  output  NUM_REQ  one-hot, registered; single-cycle completion pulse.
- rdata  output  DATA_WIDTH  fetch result; valid in the done cycle of a fetch, held until the next fetch completes.
- busy  output  1  high while state != IDLE.
- bus_r_en  output  1  slave store strobe.
- bus_w_en  output  1  slave fetch strobe.
- bus_write_data  output  DATA_WIDTH  slave store data.
- bus_read_data  input  DATA_WIDTH  slave read data.

Behaviour:
- Reset (rst_n=0 at posedge): the following are all 0 at the next edge: grant, done, rdata, busy, bus_r_en, bus_w_en, bus_write_data. State = IDLE. Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE, eligible request present:
  - Eligible set = req & ~done (a requester pulsing done this cycle is masked).
  - Winner = first eligible index scanning last+1, last+2, ... modulo NUM_REQ.
  - At the edge: grant <= onehot(winner); last <= winner; latch op[winner]; bus_write_data <= wdata slice of winner; go to ISSUE.
  - For a store, drive bus_r_en <= 1. For a fetch, drive bus_w_en <= 1.
- IDLE, no eligible request: stay in IDLE with strobes low.
- ISSUE (exactly 1 cycle; strobe high; the slave samples it at the end of this cycle):
  - Store: strobes <= 0, grant <= 0, done[winner] <= 1, go to IDLE.
  - Fetch: strobes <= 0, go to CAPTURE.
- CAPTURE (1 cycle; the slave's read_data is now updated): rdata <= bus_read_data, grant <= 0, done[winner] <= 1, go to IDLE.
- done is 0 in every cycle other than the single pulse.
- Latency from the request-sampling edge to the done pulse: store = 2 cycles, fetch = 3 cycles.
- Back-to-back: arbitration occurs in the done cycle itself, so a store stream sustains 1 transaction per 2 cycles.
- Exactly one strobe is ever high. bus_r_en and bus_w_en are never high together.
- A requester dropping req after grant does not abort; the transaction completes and done still pulses.
- op and wdata changes after grant are ignored (already latched).
- A requester with req still high in its own done cycle is masked for that cycle only; it competes again from the next cycle at lowest priority.
- Simultaneous requests: strict rotation, so no requester waits more than NUM_REQ-1 transactions.
- Reset mid-ISSUE or mid-CAPTURE: the transaction is abandoned, no done is issued, rdata is cleared, and the pointer is reset.
- bus_write_data holds its last value between transactions; it changes only at grant.

Optional Feature:
- Macro: CFG_ARB_LOCK_EN.
- When defined:
  - Adds input lock [NUM_REQ-1:0].
  - If lock[winner] is high in the cycle its done is issued, the arbiter does not mask it. In the next IDLE, if req[winner] is high, that requester wins regardless of the pointer, and the pointer does not advance.
  - Lock is released when a completed transaction sees lock low.
  - Supports atomic store-then-fetch sequences.
- When undefined: no lock port; pure round-robin as above.

Test Plan:
- Single store: req0=1, op0=0, wdata0=8'hA5 at cycle 0 -> bus_r_en=1 with bus_write_data=8'hA5 in cycle 1; done=4'b0001 in cycle 2; busy high in cycle 1 only.
- Store then fetch, requester 2: store 8'h3C, then fetch -> bus_w_en pulses 1 cycle; done=4'b0100 exactly 3 cycles after the fetch is sampled; rdata=8'h3C.
- All four req high and held, all stores, from reset -> grants in order 0,1,2,3,0; a done every 2 cycles; no requester granted twice in a row.
- Reset asserted during CAPTURE of a fetch -> next edge: all outputs 0, no done for that requester; after release, req1 and req3 pending -> requester 1 granted first.
- req dropped one cycle after grant -> done still pulses at the nominal cycle; no further grant to that requester.
- With CFG_ARB_LOCK_EN: lock0=1 with req0 and req1 held -> requester 0 is granted consecutively until lock0 drops; the next grant goes to 1.
